// File: rtl/dma_pkg.sv
// Shared DMA types: descriptor, CSR control word, transfer mode and dispatcher state.
package dma_pkg;

  localparam int unsigned DMA_DESCRIPTOR_FIFO_DEPTH = 16;

  typedef enum logic [1:0] {
    STAND_BY    = 2'd0,
    HOST_TO_DDR = 2'd1,
    DDR_TO_HOST = 2'd2,
    DDR_TO_DDR  = 2'd3
  } e_dma_mode;

  typedef struct packed {
    logic [31:0] src_addr;
    logic [31:0] dest_addr;
    logic [23:0] length;
    e_dma_mode   mode;
  } t_dma_descriptor;

  typedef struct packed {
    logic stop_dispatcher;
    logic stop_descriptors;
    logic reset_dispatcher;
  } t_dma_csr_control;

  // Exported through the status CSR.
  typedef enum logic [2:0] {
    StIdle,
    StIssue,
    StWaitDone,
    StStopped,
    StResetting
  } e_dispatch_state;

  // Descriptors that move no data are dropped without reaching the engines.
  function automatic logic desc_is_discard(input t_dma_descriptor d);
    return (d.length == '0) || (d.mode == STAND_BY);
  endfunction

endpackage

// File: rtl/dma_desc_fifo.sv
// Descriptor FIFO: power-of-2 depth, registered count/empty/full, head read from storage.
module dma_desc_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 16,
  localparam int unsigned AddrW = $clog2(Depth)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [Width-1:0] wdata,
  input  logic             pop,
  output logic [Width-1:0] rdata,
  output logic [AddrW:0]   count,
  output logic             empty,
  output logic             full
);

  logic [Width-1:0] mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q, count_d;
  logic             empty_q, full_q;
  logic             do_push, do_pop;

  // A push into a full FIFO is only legal when the head leaves in the same cycle.
  assign do_pop  = pop & ~empty_q;
  assign do_push = push & (~full_q | do_pop);

  always_comb begin
    count_d = count_q;
    if (flush) begin
      count_d = '0;
    end else if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      empty_q <= (count_d == '0);
      full_q  <= (count_d == Depth[AddrW:0]);
      if (flush) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
      end else begin
        if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = empty_q;
  assign full  = full_q;

endmodule

// File: rtl/dma_descriptor_dispatcher.sv
// Queues CSR-built descriptors and hands them one at a time to the read/write engines.
module dma_descriptor_dispatcher
  import dma_pkg::*;
#(
  parameter int unsigned DEPTH = DMA_DESCRIPTOR_FIFO_DEPTH
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  t_dma_descriptor        csr_desc,
  input  logic                   csr_desc_wr,
  input  t_dma_csr_control       csr_ctrl,
  output t_dma_descriptor        desc_out,
  output logic                   desc_valid,
  input  logic                   desc_ready,
  input  logic                   engine_done,
  input  logic                   engine_busy,
  output logic [$clog2(DEPTH):0] desc_count,
  output logic                   fifo_empty,
  output logic                   fifo_full,
  output logic                   busy,
  output logic                   stopped,
  output logic                   resetting,
  output logic                   overflow_err
);

  localparam int unsigned DescW = $bits(t_dma_descriptor);

  e_dispatch_state state_q, state_d;
  t_dma_descriptor desc_q, desc_d, head;
  logic            valid_q, valid_d;
  logic            ovf_q, ovf_d;
  logic            push, pop, flush;
  logic            empty, full;
  logic [$clog2(DEPTH):0] count;

  assign flush = csr_ctrl.reset_dispatcher;
  assign push  = csr_desc_wr & ~flush & (state_q != StResetting);

  dma_desc_fifo #(
    .Width(DescW),
    .Depth(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .reset_n(reset_n),
    .flush  (flush),
    .push   (push),
    .wdata  (csr_desc),
    .pop    (pop),
    .rdata  (head),
    .count  (count),
    .empty  (empty),
    .full   (full)
  );

  always_comb begin
    state_d = state_q;
    desc_d  = desc_q;
    valid_d = valid_q;
    pop     = 1'b0;
    if (csr_ctrl.reset_dispatcher) begin
      state_d = StResetting;
      valid_d = 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (csr_ctrl.stop_dispatcher) begin
            state_d = StStopped;
          end else if (!empty) begin
            state_d = StIssue;
            desc_d  = head;
            valid_d = ~desc_is_discard(head);
          end
        end
        StIssue: begin
          // valid_q low here means the head was judged discardable on entry.
          if (!valid_q) begin
            pop     = 1'b1;
            state_d = StIdle;
          end else if (desc_ready) begin
            pop     = 1'b1;
            valid_d = 1'b0;
            state_d = StWaitDone;
          end
        end
        StWaitDone: begin
          if (engine_done) begin
            state_d = (csr_ctrl.stop_dispatcher || csr_ctrl.stop_descriptors) ?
                      StStopped : StIdle;
          end
        end
        StStopped: begin
          if (!csr_ctrl.stop_dispatcher && !csr_ctrl.stop_descriptors) state_d = StIdle;
        end
        StResetting: begin
          if (!engine_busy) state_d = StIdle;
        end
        default: begin
          state_d = StIdle;
          valid_d = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (flush) begin
      ovf_d = 1'b0;
    end else if (csr_desc_wr && (state_q != StResetting) && full && !pop) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      desc_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      desc_q  <= desc_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign desc_out     = desc_q;
  assign desc_valid   = valid_q;
  assign desc_count   = count;
  assign fifo_empty   = empty;
  assign fifo_full    = full;
  assign busy         = (state_q != StIdle) | ~empty;
  assign stopped      = (state_q == StStopped);
  assign resetting    = (state_q == StResetting);
  assign overflow_err = ovf_q;

endmodule

// File: tb/tb_dma_descriptor_dispatcher.sv
// Directed bench with a queue-based reference model checked every cycle.
module tb_dma_descriptor_dispatcher;
  import dma_pkg::*;

  localparam int unsigned DEPTH = DMA_DESCRIPTOR_FIFO_DEPTH;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk         = 1'b0;
  logic             reset_n     = 1'b1;
  t_dma_descriptor  csr_desc    = '0;
  logic             csr_desc_wr = 1'b0;
  t_dma_csr_control csr_ctrl    = '0;
  t_dma_descriptor  desc_out;
  logic             desc_valid;
  logic             desc_ready  = 1'b0;
  logic             engine_done = 1'b0;
  logic             engine_busy = 1'b0;
  logic [CW-1:0]    desc_count;
  logic             fifo_empty, fifo_full, busy, stopped, resetting, overflow_err;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dma_descriptor_dispatcher #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .csr_desc    (csr_desc),
    .csr_desc_wr (csr_desc_wr),
    .csr_ctrl    (csr_ctrl),
    .desc_out    (desc_out),
    .desc_valid  (desc_valid),
    .desc_ready  (desc_ready),
    .engine_done (engine_done),
    .engine_busy (engine_busy),
    .desc_count  (desc_count),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .busy        (busy),
    .stopped     (stopped),
    .resetting   (resetting),
    .overflow_err(overflow_err)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a descriptor queue plus the dispatcher's phase as the rules describe it.
  typedef enum int {MIdle, MIssue, MWait, MStop, MRst} m_phase_t;
  m_phase_t        m_ph    = MIdle;
  t_dma_descriptor m_q[$];
  t_dma_descriptor m_out   = '0;
  bit              m_valid = 1'b0;
  bit              m_ovf   = 1'b0;

  function automatic bit is_dead(input t_dma_descriptor d);
    return (d.length == 24'd0) || (d.mode == STAND_BY);
  endfunction

  task automatic model_step();
    int sz;
    bit take;
    bit was_rst;
    sz      = m_q.size();
    take    = 1'b0;
    was_rst = (m_ph == MRst);
    if (csr_ctrl.reset_dispatcher) begin
      m_q.delete();
      m_ph    = MRst;
      m_valid = 1'b0;
      m_ovf   = 1'b0;
      return;
    end
    case (m_ph)
      MIdle: begin
        if (csr_ctrl.stop_dispatcher) m_ph = MStop;
        else if (sz > 0) begin
          m_ph    = MIssue;
          m_valid = !is_dead(m_q[0]);
          if (m_valid) m_out = m_q[0];
        end
      end
      MIssue: begin
        if (!m_valid) begin
          take = 1'b1;
          m_ph = MIdle;
        end else if (desc_ready) begin
          take    = 1'b1;
          m_valid = 1'b0;
          m_ph    = MWait;
        end
      end
      MWait: if (engine_done)
        m_ph = (csr_ctrl.stop_dispatcher || csr_ctrl.stop_descriptors) ? MStop : MIdle;
      MStop: if (!csr_ctrl.stop_dispatcher && !csr_ctrl.stop_descriptors) m_ph = MIdle;
      MRst:  if (!engine_busy) m_ph = MIdle;
      default: m_ph = MIdle;
    endcase
    if (take) void'(m_q.pop_front());
    if (csr_desc_wr && !was_rst) begin
      if (sz < int'(DEPTH) || take) m_q.push_back(csr_desc);
      else m_ovf = 1'b1;
    end
  endtask

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      m_q.delete();
      m_ph    = MIdle;
      m_valid = 1'b0;
      m_out   = '0;
      m_ovf   = 1'b0;
    end else begin
      model_step();
    end
  end

  initial forever begin
    @(negedge clk);
    chk("cmp_count", 128'(desc_count), 128'(m_q.size()));
    chk("cmp_empty", 128'(fifo_empty), 128'(m_q.size() == 0));
    chk("cmp_full", 128'(fifo_full), 128'(m_q.size() == int'(DEPTH)));
    chk("cmp_valid", 128'(desc_valid), 128'(m_valid));
    if (m_valid) chk("cmp_desc_out", 128'(desc_out), 128'(m_out));
    chk("cmp_busy", 128'(busy), 128'((m_ph != MIdle) || (m_q.size() > 0)));
    chk("cmp_stopped", 128'(stopped), 128'(m_ph == MStop));
    chk("cmp_resetting", 128'(resetting), 128'(m_ph == MRst));
    chk("cmp_overflow", 128'(overflow_err), 128'(m_ovf));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input t_dma_descriptor d);
    csr_desc    = d;
    csr_desc_wr = 1'b1;
    tick();
    csr_desc_wr = 1'b0;
  endtask

  task automatic done_pulse();
    engine_done = 1'b1;
    tick();
    engine_done = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    for (int i = 0; i < 20; i++) begin
      if (desc_valid) break;
      tick();
    end
    n_tests++;
    if (!desc_valid) begin
      n_fail++;
      $display("FAIL %s: desc_valid still 0 after 20 cycles, expected 1", name);
    end
  endtask

  // Accept one issued descriptor, check its source address, then complete it.
  task automatic take_one(input string name, input logic [31:0] src);
    desc_ready = 1'b1;
    wait_valid(name);
    chk(name, 128'(desc_out.src_addr), 128'(src));
    tick();
    done_pulse();
  endtask

  function automatic t_dma_descriptor mk(input logic [31:0] s, input logic [31:0] d,
                                         input logic [23:0] l, input e_dma_mode m);
    t_dma_descriptor r;
    r.src_addr  = s;
    r.dest_addr = d;
    r.length    = l;
    r.mode      = m;
    return r;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int rst_cycles;
    #2 reset_n = 1'b0;
    repeat (3) tick();
    chk("rst_valid", 128'(desc_valid), 128'(0));
    chk("rst_desc_out", 128'(desc_out), 128'(0));
    chk("rst_empty", 128'(fifo_empty), 128'(1));
    chk("rst_full", 128'(fifo_full), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    reset_n = 1'b1;
    tick();

    // Basic issue: two-cycle latency, count 1 then 0 on handshake.
    desc_ready = 1'b1;
    push(mk(32'h1000, 32'h2000, 24'd64, HOST_TO_DDR));
    chk("t1_count_one", 128'(desc_count), 128'(1));
    chk("t1_valid_early", 128'(desc_valid), 128'(0));
    tick();
    chk("t1_valid_c2", 128'(desc_valid), 128'(1));
    chk("t1_src", 128'(desc_out.src_addr), 128'(32'h1000));
    chk("t1_dest", 128'(desc_out.dest_addr), 128'(32'h2000));
    chk("t1_len", 128'(desc_out.length), 128'(64));
    chk("t1_mode", 128'(desc_out.mode), 128'(HOST_TO_DDR));
    tick();
    chk("t1_count_zero", 128'(desc_count), 128'(0));
    chk("t1_valid_drop", 128'(desc_valid), 128'(0));
    done_pulse();

    // Discard: zero-length head vanishes, only the second descriptor issues.
    push(mk(32'hDEAD, 32'h0, 24'd0, HOST_TO_DDR));
    push(mk(32'h3000, 32'h4000, 24'd16, DDR_TO_HOST));
    take_one("t2_second_only", 32'h3000);
    chk("t2_empty", 128'(fifo_empty), 128'(1));

    // Full and overflow: 17 pushes, last one dropped.
    desc_ready = 1'b0;
    for (int i = 0; i < 17; i++) push(mk(32'(i), 32'h8000 + 32'(i), 24'd8, DDR_TO_DDR));
    chk("t3_full", 128'(fifo_full), 128'(1));
    chk("t3_count", 128'(desc_count), 128'(16));
    chk("t3_overflow", 128'(overflow_err), 128'(1));
    for (int i = 0; i < 16; i++) take_one("t3_order", 32'(i));
    repeat (4) tick();
    chk("t3_no_17th", 128'(desc_valid), 128'(0));
    csr_ctrl.reset_dispatcher = 1'b1;
    tick();
    csr_ctrl.reset_dispatcher = 1'b0;
    chk("t3_ovf_cleared", 128'(overflow_err), 128'(0));
    tick();
    chk("t3_back_idle", 128'(resetting), 128'(0));

    // Full with simultaneous push and handshake.
    desc_ready = 1'b0;
    for (int i = 0; i < 16; i++) push(mk(32'h100 + 32'(i), 32'h0, 24'd4, HOST_TO_DDR));
    chk("t4_full", 128'(fifo_full), 128'(1));
    desc_ready = 1'b1;
    push(mk(32'h200, 32'h0, 24'd4, HOST_TO_DDR));
    chk("t4_count_kept", 128'(desc_count), 128'(16));
    chk("t4_no_overflow", 128'(overflow_err), 128'(0));
    done_pulse();
    for (int i = 1; i < 16; i++) take_one("t4_order", 32'h100 + 32'(i));
    take_one("t4_last", 32'h200);
    chk("t4_empty", 128'(fifo_empty), 128'(1));

    // Stop after completion, then resume.
    push(mk(32'h5000, 32'h0, 24'd32, DDR_TO_HOST));
    wait_valid("t5_first");
    tick();
    csr_ctrl.stop_descriptors = 1'b1;
    for (int i = 0; i < 3; i++) push(mk(32'h5100 + 32'(i), 32'h0, 24'd32, DDR_TO_HOST));
    done_pulse();
    repeat (2) tick();
    chk("t5_stopped", 128'(stopped), 128'(1));
    chk("t5_held", 128'(desc_count), 128'(3));
    chk("t5_no_issue", 128'(desc_valid), 128'(0));
    csr_ctrl.stop_descriptors = 1'b0;
    repeat (2) tick();
    chk("t5_resume", 128'(desc_valid), 128'(1));
    chk("t5_resume_src", 128'(desc_out.src_addr), 128'(32'h5100));
    tick();
    done_pulse();
    take_one("t5_order", 32'h5101);
    take_one("t5_order", 32'h5102);

    // Reset mid-operation with the engines still busy.
    desc_ready = 1'b0;
    for (int i = 0; i < 5; i++) push(mk(32'h600 + 32'(i), 32'h0, 24'd2, DDR_TO_DDR));
    chk("t6_in_issue", 128'(desc_valid), 128'(1));
    chk("t6_queued", 128'(desc_count), 128'(5));
    csr_ctrl.reset_dispatcher = 1'b1;
    engine_busy = 1'b1;
    tick();
    csr_ctrl.reset_dispatcher = 1'b0;
    chk("t6_valid_drop", 128'(desc_valid), 128'(0));
    chk("t6_flushed", 128'(desc_count), 128'(0));
    rst_cycles = resetting ? 1 : 0;
    for (int i = 1; i < 10; i++) begin
      if (i == 3) begin
        csr_desc    = mk(32'h700, 32'h0, 24'd2, DDR_TO_DDR);
        csr_desc_wr = 1'b1;
      end
      tick();
      csr_desc_wr = 1'b0;
      if (resetting) rst_cycles++;
    end
    chk("t6_push_refused", 128'(desc_count), 128'(0));
    engine_busy = 1'b0;
    tick();
    chk("t6_rst_cycles", 128'(rst_cycles), 128'(10));
    chk("t6_idle", 128'(resetting), 128'(0));
    chk("t6_not_busy", 128'(busy), 128'(0));

    repeat (2) tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dma_descriptor_dispatcher.md
DMA_DESCRIPTOR_DISPATCHER -- requirements
Module: dma_descriptor_dispatcher

Interface
REQ-001 The block SHALL have a parameter DEPTH, default DMA_DESCRIPTOR_FIFO_DEPTH (16), giving the descriptor FIFO entries; it SHALL be a power of 2 in the range 8..1024.
REQ-002 The block SHALL have one clock, clk; reset is reset_n, asynchronous, active-low.
REQ-003 Ports, in the form name, direction, width, meaning:
- clk, in, 1, sole clock.
- reset_n, in, 1, async active-low reset.
- csr_desc, in, t_dma_descriptor, descriptor assembled by the CSR block.
- csr_desc_wr, in, 1, one-cycle push strobe (CSR write with go=1).
- csr_ctrl, in, t_dma_csr_control, live control register.
- desc_out, out, t_dma_descriptor, descriptor issued to the read/write engines.
- desc_valid, out, 1, desc_out valid.
- desc_ready, in, 1, engines accept desc_out.
- engine_done, in, 1, one-cycle pulse: issued descriptor complete.
- engine_busy, in, 1, engines hold outstanding traffic.
- desc_count, out, $clog2(DEPTH)+1, FIFO occupancy.
- fifo_empty, out, 1, occupancy == 0.
- fifo_full, out, 1, occupancy == DEPTH.
- busy, out, 1, state != IDLE or FIFO not empty.
- stopped, out, 1, state == STOPPED.
- resetting, out, 1, state == RESETTING.
- overflow_err, out, 1, sticky flag: a push was dropped.

Function
REQ-004 Push: when csr_desc_wr=1, csr_desc SHALL be written to the FIFO in the same cycle unless one of these holds:
- the FIFO is full with no pop that cycle; or
- state is RESETTING.
REQ-005 A push refused while the FIFO is full SHALL set overflow_err; the descriptor is dropped.
REQ-006 When the FIFO is full, a push and a pop in the same cycle SHALL both succeed and desc_count SHALL be unchanged.
REQ-007 desc_count SHALL follow these rules:
- +1 on push only; -1 on pop only; unchanged on both or neither.
- It SHALL never wrap.
- Pointers SHALL wrap modulo DEPTH.
REQ-008 The FSM SHALL have the states IDLE, ISSUE, WAIT_DONE, STOPPED and RESETTING.
REQ-009 From IDLE:
- If the FIFO is not empty and stop_dispatcher=0, go to ISSUE.
- If stop_dispatcher=1, go to STOPPED.
REQ-010 Entering ISSUE SHALL register the FIFO head into desc_out, with desc_valid=1 on the next cycle.
REQ-011 desc_out SHALL hold stable until desc_ready=1.
REQ-012 The head SHALL pop in the cycle desc_valid and desc_ready are both 1; the FSM then goes to WAIT_DONE.
REQ-013 A head with length==0 or mode==STAND_BY SHALL be popped and discarded in one cycle: no desc_valid, return to IDLE.
REQ-014 From WAIT_DONE:
- On engine_done, go to STOPPED if stop_dispatcher=1 or stop_descriptors=1, otherwise go to IDLE.
- An engine_done in any other state SHALL be ignored.
REQ-015 From STOPPED:
- When both stop_dispatcher and stop_descriptors are 0, go to IDLE.
- The FIFO SHALL keep accepting pushes.
REQ-016 reset_dispatcher=1 in any state SHALL take priority over all other transitions:
- go to RESETTING;
- flush the FIFO (pointers and count set to 0);
- drop desc_valid in the next cycle;
- clear overflow_err.
REQ-017 RESETTING SHALL be held while reset_dispatcher=1 or engine_busy=1, then go to IDLE.
REQ-018 Issue latency SHALL be 2 cycles, from a push into an empty IDLE dispatcher to desc_valid=1.

Reset
REQ-019 On reset_n low, asynchronously:
- state = IDLE;
- pointers and desc_count = 0;
- desc_valid = 0, desc_out = 0;
- overflow_err = 0, busy = 0, stopped = 0, resetting = 0;
- fifo_empty = 1, fifo_full = 0.
REQ-020 Reset deassertion SHALL take effect on the first clk edge after reset_n rises; no output SHALL glitch in that cycle.

Structure
REQ-021 t_dma_descriptor, t_dma_csr_control, e_dma_mode and DMA_DESCRIPTOR_FIFO_DEPTH SHALL come from dma_pkg.
REQ-022 A new enum e_dispatch_state SHALL be added to dma_pkg so the status CSR can export it.
REQ-023 The FIFO SHALL be one sub-module, dma_desc_fifo, with these properties:
- parameterised on width and depth;
- push/pop/count;
- registered outputs;
- no FSM logic.

Verification
REQ-024 Basic issue: push descriptor (src=0x1000, dest=0x2000, length=64, mode=HOST_TO_DDR) -> desc_valid=1 at cycle +2 with matching fields; desc_count goes 1 then 0 on the handshake.
REQ-025 Full and overflow: 17 pushes with desc_ready=0 -> fifo_full=1, desc_count=16, overflow_err=1, and the 17th descriptor is absent on drain.
REQ-026 Full, simultaneous push/pop: FIFO full, push and handshake in the same cycle -> desc_count stays 16, overflow_err stays 0, and order is preserved.
REQ-027 Stop: stop_descriptors=1 during WAIT_DONE -> STOPPED after engine_done, 3 queued entries held; clear the stop -> the next descriptor issues within 2 cycles.
REQ-028 Reset mid-operation: reset_dispatcher pulse while in ISSUE with 5 queued and engine_busy=1 for 10 more cycles -> desc_valid=0 next cycle, desc_count=0, resetting=1 for 10 cycles, then IDLE.
REQ-029 Discard: push length=0 then a valid descriptor -> only the second appears on desc_out.
